passthru_arbiter: RTL and testbench
===================================

# passthru_arbiter

Round-robin arbiter that shares one DATA_WIDTH pass-through datapath between NUM_REQ requesters. It sits in front of the pass-through stage and grants one requester at a time for a whole packet, delimited by `last`. It drives a registered output beat tagged with the source index, with full valid/ready back-pressure. Packets from different requesters never interleave.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..16.
- DATA_WIDTH, default 8: datapath width in bits.
- SRC_W, default $clog2(NUM_REQ): width of the source index (derived, not overridden).

- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester last beat of packet.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- out_valid  output  1  output beat valid (registered).
- out_data  output  DATA_WIDTH  output data (registered).
- out_last  output  1  last beat of packet (registered).
- out_src  output  SRC_W  index of the requester that produced the beat (registered).
- out_ready  input  1  downstream accept.
- busy  output  1  high while in LOCK.

## Operation
- State machine has two states, IDLE and LOCK. It holds registers `gnt` (SRC_W bits) and `ptr` (last-served index).
- IDLE:
  - If any req_valid is set, pick the first set index searching ptr+1, ptr+2, … modulo NUM_REQ.
  - Register that index into `gnt` and go to LOCK.
  - req_ready is all zero in IDLE.
- LOCK:
  - req_ready[gnt] = !out_valid || out_ready. All other req_ready bits are 0.
  - A beat is accepted when req_valid[gnt] && req_ready[gnt].
  - On accept, load out_data/out_last/out_src from requester gnt and set out_valid.
  - If the accepted beat has req_last=1, go to IDLE and set ptr <= gnt.
- Output register:
  - out_valid clears when out_ready=1 and no new beat is accepted in the same cycle.
  - Output fields hold stable while out_valid && !out_ready.
- Requests from non-granted requesters are ignored until the current packet ends. There is no preemption and no timeout.
- If req_valid[gnt] drops mid-packet, the block stays in LOCK and waits; the grant is not released.
- Single-beat packets are legal: the first beat has last=1.
- Fairness: under continuous requests from all requesters, service order is strictly rotating.

## Timing
- Reset values (asynchronous assert, synchronous-safe deassert): state=IDLE, ptr=NUM_REQ-1 (requester 0 has first priority), gnt=0, out_valid=0, out_data=0, out_last=0, out_src=0, busy=0, req_ready=0.
- Grant latency: req_valid rises in cycle n (state IDLE) → LOCK and req_ready high in cycle n+1.
- Data latency: beat accepted at the edge ending cycle k → out_valid/out_data visible in cycle k+1.
- First-beat latency from request to out_valid is 2 cycles.
- One-cycle arbitration bubble after each packet: the last beat is accepted at edge k, the block is in IDLE in cycle k+1, and the next grant is in LOCK in cycle k+2.
- Sustained throughput inside a packet is 1 beat/cycle while out_ready=1.
- Back-pressure: out_valid=1 with out_ready=0 → req_ready=0 in the same cycle (combinational from out_valid/out_ready).
- Simultaneous out_ready=1 and new accept: the register reloads, out_valid stays 1, and there is no bubble.
- Reset mid-packet: all state is cleared immediately and the partial packet is dropped. The next grant after reset goes to the lowest valid index starting from 0.

## Test plan
- Reset then idle: hold rst_n=0 with random inputs → all outputs at reset values. Release with no requests → busy=0, out_valid=0.
- Single requester: req 2 sends 3 beats A5, 3C, FF (last on FF) with out_ready=1 → out beats A5, 3C, FF with out_src=2, out_last only on FF. The first out_valid is 2 cycles after req_valid.
- Round-robin: all 4 requesters continuously send 2-beat packets → out_src sequence 0,0,1,1,2,2,3,3,0,0. Exactly one idle cycle between packets.
- Back-pressure: during a 4-beat packet from req 1, hold out_ready=0 for 3 cycles on beat 2 → out_data stable, req_ready[1]=0 during the stall, no beat lost or duplicated.
- Mid-packet gap and contention: req 0 drops valid for 2 cycles mid-packet while req 3 requests → grant stays on 0 (busy=1, out_src never 3) until req 0's last beat, then req 3 is served.
- Reset mid-packet: assert rst_n=0 after beat 1 of a 3-beat packet → out_valid drops immediately. After release, a fresh packet from req 1 passes intact.

Source files
------------

// File: rtl/passthru_arbiter.sv
// Round-robin packet arbiter in front of a registered pass-through stage.
// A requester keeps the grant until its last beat, so packets never interleave.
module passthru_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int SRC_W      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [SRC_W-1:0]              out_src,
    input  logic                          out_ready,
    output logic                          busy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state_reg, state_next;
    logic [SRC_W-1:0]   gnt_reg, gnt_next;
    logic [SRC_W-1:0]   ptr_reg, ptr_next;

    logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
    logic               take_ready;
    logic               accept;
    logic               pick_found;
    logic [SRC_W-1:0]   pick_idx;
    logic [SRC_W-1:0]   cand;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // The output register can take a new beat when empty or draining this cycle.
    assign take_ready = !out_valid || out_ready;
    assign accept     = (state_reg == LOCK) && req_valid[gnt_reg] && take_ready;

    // Search ptr+NUM_REQ down to ptr+1 so the nearest requester after ptr wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = SRC_W'((int'(ptr_reg) + off) % NUM_REQ);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            gnt_reg   <= '0;
            ptr_reg   <= SRC_W'(NUM_REQ - 1);
        end else begin
            state_reg <= state_next;
            gnt_reg   <= gnt_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        gnt_next   = gnt_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (pick_found) begin
                    gnt_next   = pick_idx;
                    state_next = LOCK;
                end
            end
            LOCK: begin
                if (accept && req_last[gnt_reg]) begin
                    state_next = IDLE;
                    ptr_next   = gnt_reg;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        if (state_reg == LOCK) begin
            req_ready[gnt_reg] = take_ready;
            busy               = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= data_arr[gnt_reg];
            out_last  <= req_last[gnt_reg];
            out_src   <= gnt_reg;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_passthru_arbiter.sv
// Directed bench for passthru_arbiter: a per-cycle vector table, then
// hand-written sequences for rotation, stalls, valid gaps and mid-packet reset.
module tb_passthru_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic [1:0]  out_src;
    logic        out_ready;
    logic        busy;

    passthru_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        ordy;
        logic [3:0]  e_ready;
        logic        e_ov;
        logic [7:0]  e_data;
        logic        e_last;
        logic [1:0]  e_src;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  vecs [10];
    beat_t rcv [$];

    logic [7:0] pkt  [4][8];
    int         plen [4];
    int         pidx [4];
    bit         en   [4];
    bit         rep  [4];
    int         stall_cnt;
    logic [7:0] stall_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic clear_tb();
        for (int i = 0; i < 4; i++) begin
            en[i] = 0; rep[i] = 0; plen[i] = 0; pidx[i] = 0;
            for (int j = 0; j < 8; j++) pkt[i][j] = 8'h00;
        end
        rcv.delete();
        stall_cnt = 0;
        stall_val = 8'h00;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_tb();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One cycle: drive sources at the falling edge, then log handshakes.
    task automatic tick(input logic ordy);
        bit    stalled;
        beat_t b;
        @(negedge clk);
        stalled   = 0;
        out_ready = ordy;
        if (stall_cnt > 0 && out_valid && out_data == stall_val) begin
            out_ready = 1'b0;
            stall_cnt--;
            stalled = 1;
        end
        for (int i = 0; i < 4; i++) begin
            req_valid[i]        = en[i] && (pidx[i] < plen[i]);
            req_data[i*8 +: 8]  = pkt[i][pidx[i] % 8];
            req_last[i]         = (pidx[i] == plen[i] - 1);
        end
        #1;
        chk("onehot_ready", 32'($countones(req_ready) <= 1), 1);
        if (stalled) chk("stall_ready", 32'(req_ready), 0);
        for (int i = 0; i < 4; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pidx[i]++;
                if (rep[i] && pidx[i] == plen[i]) pidx[i] = 0;
            end
        end
        if (out_valid && out_ready) begin
            b.src = out_src; b.data = out_data; b.last = out_last;
            rcv.push_back(b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   gap;
        bit   seen_lock;
        bit   prev_busy;
        int   rr_src [10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
        logic [7:0] bp_exp [4]  = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [7:0] gp_exp [4]  = '{8'hA0, 8'hA1, 8'hA2, 8'hD0};
        logic [1:0] gp_src [4]  = '{2'd0, 2'd0, 2'd0, 2'd3};
        logic [7:0] rs_exp [3]  = '{8'hC1, 8'hC2, 8'hC3};

        rst_n = 1'b0;
        clear_tb();

        // Reset with junk inputs, release, then a 3-beat packet from requester 2.
        vecs[0] = '{1'b0, 4'hF, 32'hDEADBEEF, 4'hF, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[1] = '{1'b0, 4'h5, 32'h12345678, 4'hA, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[2] = '{1'b1, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[3] = '{1'b1, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[4] = '{1'b1, 4'h4, 32'h00A50000, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
        vecs[5] = '{1'b1, 4'h4, 32'h00A50000, 4'h0, 1'b1, 4'h4, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
        vecs[6] = '{1'b1, 4'h4, 32'h003C0000, 4'h0, 1'b1, 4'h4, 1'b1, 8'hA5, 1'b0, 2'd2, 1'b1};
        vecs[7] = '{1'b1, 4'h4, 32'h00FF0000, 4'h4, 1'b1, 4'h4, 1'b1, 8'h3C, 1'b0, 2'd2, 1'b1};
        vecs[8] = '{1'b1, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b1, 8'hFF, 1'b1, 2'd2, 1'b0};
        vecs[9] = '{1'b1, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst_n     = vecs[k].rst_n;
            req_valid = vecs[k].valid;
            req_data  = vecs[k].data;
            req_last  = vecs[k].last;
            out_ready = vecs[k].ordy;
            #1;
            chk($sformatf("vec%0d_ready", k), 32'(req_ready), 32'(vecs[k].e_ready));
            chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'(vecs[k].e_ov));
            chk($sformatf("vec%0d_busy", k),  32'(busy),      32'(vecs[k].e_busy));
            if (vecs[k].e_ov || !vecs[k].rst_n) begin
                chk($sformatf("vec%0d_data", k), 32'(out_data), 32'(vecs[k].e_data));
                chk($sformatf("vec%0d_last", k), 32'(out_last), 32'(vecs[k].e_last));
                chk($sformatf("vec%0d_src", k),  32'(out_src),  32'(vecs[k].e_src));
            end
            $display("vec %0d ready=%h valid=%b data=%h last=%b src=%0d busy=%b",
                     k, req_ready, out_valid, out_data, out_last, out_src, busy);
        end

        // Round-robin: all four requesters stream 2-beat packets.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            en[i] = 1; rep[i] = 1; plen[i] = 2;
            pkt[i][0] = 8'(16 * i);
            pkt[i][1] = 8'(16 * i + 1);
        end
        n = 0; gap = 0; seen_lock = 0; prev_busy = 0;
        while (rcv.size() < 10 && n < 100) begin
            tick(1'b1);
            n++;
            if (busy && !prev_busy && seen_lock) chk("rr_gap", 32'(gap), 1);
            if (busy) begin seen_lock = 1; gap = 0; end
            else if (seen_lock) gap++;
            prev_busy = busy;
        end
        chk("rr_count", 32'(rcv.size()), 10);
        for (int k = 0; k < rcv.size() && k < 10; k++) begin
            chk($sformatf("rr%0d_src", k),  32'(rcv[k].src),  32'(rr_src[k]));
            chk($sformatf("rr%0d_data", k), 32'(rcv[k].data), 32'(16 * rr_src[k] + k % 2));
            chk($sformatf("rr%0d_last", k), 32'(rcv[k].last), 32'(k % 2));
            $display("rr beat %0d src=%0d data=%h last=%b", k, rcv[k].src, rcv[k].data, rcv[k].last);
        end

        // Back-pressure: stall three cycles while beat 0x22 is presented.
        do_reset();
        en[1] = 1; plen[1] = 4;
        for (int j = 0; j < 4; j++) pkt[1][j] = bp_exp[j];
        stall_cnt = 3; stall_val = 8'h22;
        n = 0;
        while (rcv.size() < 4 && n < 60) begin tick(1'b1); n++; end
        chk("bp_stalls_done", 32'(stall_cnt), 0);
        chk("bp_count", 32'(rcv.size()), 4);
        for (int k = 0; k < rcv.size() && k < 4; k++) begin
            chk($sformatf("bp%0d_data", k), 32'(rcv[k].data), 32'(bp_exp[k]));
            chk($sformatf("bp%0d_src", k),  32'(rcv[k].src),  1);
            chk($sformatf("bp%0d_last", k), 32'(rcv[k].last), 32'(k == 3));
            $display("bp beat %0d src=%0d data=%h last=%b", k, rcv[k].src, rcv[k].data, rcv[k].last);
        end

        // Mid-packet valid gap on requester 0 while requester 3 waits.
        do_reset();
        en[0] = 1; plen[0] = 3; pkt[0][0] = 8'hA0; pkt[0][1] = 8'hA1; pkt[0][2] = 8'hA2;
        en[3] = 1; plen[3] = 1; pkt[3][0] = 8'hD0;
        n = 0;
        while (pidx[0] < 1 && n < 20) begin tick(1'b1); n++; end
        chk("gap_first_beat", 32'(pidx[0]), 1);
        en[0] = 0;
        for (int c = 0; c < 2; c++) begin
            tick(1'b1);
            chk("gap_busy", 32'(busy), 1);
            chk("gap_ready3", 32'(req_ready[3]), 0);
            chk("gap_src_not3", 32'(!(out_valid && out_src == 2'd3)), 1);
        end
        en[0] = 1;
        n = 0;
        while (rcv.size() < 4 && n < 40) begin tick(1'b1); n++; end
        chk("gap_count", 32'(rcv.size()), 4);
        for (int k = 0; k < rcv.size() && k < 4; k++) begin
            chk($sformatf("gap%0d_src", k),  32'(rcv[k].src),  32'(gp_src[k]));
            chk($sformatf("gap%0d_data", k), 32'(rcv[k].data), 32'(gp_exp[k]));
            $display("gap beat %0d src=%0d data=%h last=%b", k, rcv[k].src, rcv[k].data, rcv[k].last);
        end

        // Reset after the first beat of a 3-beat packet, then a clean packet.
        do_reset();
        en[2] = 1; plen[2] = 3; pkt[2][0] = 8'hB0; pkt[2][1] = 8'hB1; pkt[2][2] = 8'hB2;
        n = 0;
        while (!out_valid && n < 20) begin tick(1'b1); n++; end
        chk("rst_beat1_seen", 32'(out_valid), 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(req_ready), 0);
        $display("reset mid-packet valid=%b busy=%b ready=%h", out_valid, busy, req_ready);
        clear_tb();
        @(negedge clk);
        rst_n = 1'b1;
        en[1] = 1; plen[1] = 3;
        for (int j = 0; j < 3; j++) pkt[1][j] = rs_exp[j];
        n = 0;
        while (rcv.size() < 3 && n < 30) begin tick(1'b1); n++; end
        chk("rst_count", 32'(rcv.size()), 3);
        for (int k = 0; k < rcv.size() && k < 3; k++) begin
            chk($sformatf("rst%0d_src", k),  32'(rcv[k].src),  1);
            chk($sformatf("rst%0d_data", k), 32'(rcv[k].data), 32'(rs_exp[k]));
            chk($sformatf("rst%0d_last", k), 32'(rcv[k].last), 32'(k == 2));
            $display("rst beat %0d src=%0d data=%h last=%b", k, rcv[k].src, rcv[k].data, rcv[k].last);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
